// File: rtl/add2p_sum_fifo.sv
// add2p_sum_fifo: consumer stage behind the 3-stage pipelined adder (9/9/10
// split). It follows each valid operand pair through the adder's fixed
// latency, lines the two test carries up with their sum word, and buffers
// {sum, carries} in a first-word-fall-through FIFO. The adder cannot stall,
// so a result arriving at a full FIFO (with no read that cycle) is dropped,
// counted in a saturating counter and flagged in a sticky overflow bit.
//
// Optional macro ADD2P_SUM_FIFO_CARRY_EN: when defined, the carry delay
// registers exist, the FIFO word is WIDTH+2 bits and out_lcy/out_mcy carry
// the aligned flags. When undefined, the carry inputs are unused, the FIFO
// word is WIDTH bits and out_lcy/out_mcy are tied to 0.
//
// Output handshake: out_valid is high whenever the FIFO holds an entry and
// the head word is shown on out_data/out_lcy/out_mcy; the head is consumed
// on a rising edge where out_valid && out_ready, and it stays stable while
// out_valid=1 and out_ready=0. out_ready is ignored while out_valid=0.
module add2p_sum_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int LAT   = 4,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] sum,
  input  logic             lsbs_carry,
  input  logic             msbs_carry,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lcy,
  output logic             out_mcy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic             overflow,
  output logic [CW-1:0]    drop_cnt
);

`ifdef ADD2P_SUM_FIFO_CARRY_EN
  localparam int FW = WIDTH + 2;
`else
  localparam int FW = WIDTH;
`endif

  logic [LAT-1:0] vld_q, vld_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [FW-1:0]  mem_q [DEPTH];
  logic [FW-1:0]  mem_d [DEPTH];
  logic [FW-1:0]  wdata;
  logic [FW-1:0]  head;
  logic           wr_en, rd, wr_ok, drop;

  // Token shift register: tap LAT lines up with the adder's registered sum.
  always_comb begin
    vld_d = {vld_q[LAT-2:0], in_valid};
  end

  assign wr_en = vld_q[LAT-1];

`ifdef ADD2P_SUM_FIFO_CARRY_EN
  logic [1:0] lcy_q, lcy_d;
  logic       mcy_q, mcy_d;

  // LSB carry appears 2 clocks after operands, MSB carry 3; delay both to LAT.
  always_comb begin
    lcy_d = {lcy_q[0], lsbs_carry};
    mcy_d = msbs_carry;
  end

  // Carry delay registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lcy_q <= 2'b00;
      mcy_q <= 1'b0;
    end else begin
      lcy_q <= lcy_d;
      mcy_q <= mcy_d;
    end
  end

  assign wdata = {sum, lcy_q[1], mcy_q};
`else
  logic unused_carries;
  assign unused_carries = lsbs_carry ^ msbs_carry;
  assign wdata          = sum;
`endif

  // Status flags and first-word-fall-through head, zeroed while empty.
  always_comb begin
    out_valid = (count_q != '0);
    full      = (count_q == (AW+1)'(DEPTH));
    head      = mem_q[rptr_q];
    out_data  = '0;
    out_lcy   = 1'b0;
    out_mcy   = 1'b0;
    if (out_valid) begin
`ifdef ADD2P_SUM_FIFO_CARRY_EN
      out_data = head[FW-1:2];
      out_lcy  = head[1];
      out_mcy  = head[0];
`else
      out_data = head;
`endif
    end
  end

  // Read/write/drop decisions; a read in the same cycle frees a full slot.
  always_comb begin
    rd         = out_valid & out_ready;
    wr_ok      = wr_en & (~full | rd);
    drop       = wr_en & full & ~rd;
    wptr_d     = wr_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = rd ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q;
    if (wr_ok && !rd) begin
      count_d = count_q + 1'b1;
    end else if (rd && !wr_ok) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {CW{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Next FIFO storage contents: only the slot at wptr changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[wptr_q] = wdata;
    end
  end

  // FIFO storage has no reset; its contents are masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state: token pipe, pointers, occupancy and drop bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      vld_q      <= vld_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_add2p_sum_fifo.sv
// Bench for add2p_sum_fifo: a behavioural 28-bit adder with 9/9/10 timing
// feeds the DUT; a queue-based reference model predicts FIFO contents, drops
// and overflow from the arrival/read rules.
`timescale 1ns/1ps
module tb_add2p_sum_fifo;
  localparam int WIDTH = 28;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int LAT   = 4;
  localparam int CW    = 8;
  localparam int W     = WIDTH + 2;
`ifdef ADD2P_SUM_FIFO_CARRY_EN
  localparam bit CY = 1'b1;
`else
  localparam bit CY = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;

  // behavioural pipelined adder
  logic [WIDTH-1:0] s1 = '0, s2 = '0, s3 = '0, sum_r = '0;
  logic l1 = 1'b0, lsbs_r = 1'b0, m1 = 1'b0, m2 = 1'b0, msbs_r = 1'b0;

  function automatic logic add_lc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [9:0] t;
    t = {1'b0, a[8:0]} + {1'b0, b[8:0]};
    return t[9];
  endfunction

  function automatic logic add_mc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [18:0] t;
    t = {1'b0, a[17:0]} + {1'b0, b[17:0]};
    return t[18];
  endfunction

  function automatic logic [W-1:0] exp_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] s;
    s = a + b;
    return {s, CY & add_lc(a, b), CY & add_mc(a, b)};
  endfunction

  always @(posedge clk) begin
    s1     <= x + y;
    s2     <= s1;
    s3     <= s2;
    sum_r  <= s3;
    l1     <= add_lc(x, y);
    lsbs_r <= l1;
    m1     <= add_mc(x, y);
    m2     <= m1;
    msbs_r <= m2;
  end

  // DUT outputs
  logic [WIDTH-1:0] out_data, out_data2;
  logic             out_lcy, out_mcy, out_valid, full, overflow;
  logic             out_lcy2, out_mcy2, out_valid2, full2, overflow2;
  logic [CW-1:0]    drop_cnt;
  logic [1:0]       drop_cnt2;

  add2p_sum_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .LAT(LAT), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sum(sum_r),
    .lsbs_carry(lsbs_r), .msbs_carry(msbs_r), .out_data(out_data),
    .out_lcy(out_lcy), .out_mcy(out_mcy), .out_valid(out_valid),
    .out_ready(out_ready), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // Narrow-counter instance sharing all inputs, for the saturation check.
  add2p_sum_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .LAT(LAT), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sum(sum_r),
    .lsbs_carry(lsbs_r), .msbs_carry(msbs_r), .out_data(out_data2),
    .out_lcy(out_lcy2), .out_mcy(out_mcy2), .out_valid(out_valid2),
    .out_ready(out_ready), .full(full2), .overflow(overflow2), .drop_cnt(drop_cnt2)
  );

  // scoreboard / reference model
  logic [W-1:0] exp_q[$];
  logic [W-1:0] tok_w[$];
  int           tok_due[$];
  int           cyc = 0;
  int           drop_raw = 0;
  logic         ovf_m = 1'b0;
  int           n_tests = 0;
  int           n_fail = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        exp_q.delete();
        tok_w.delete();
        tok_due.delete();
        drop_raw = 0;
        ovf_m = 1'b0;
      end else begin : model_step
        logic         rd_m, arr;
        logic [W-1:0] aw;
        cyc++;
        aw = '0;
        rd_m = (exp_q.size() != 0) && out_ready;
        arr = 1'b0;
        if (tok_due.size() != 0 && tok_due[0] == cyc) begin
          arr = 1'b1;
          aw = tok_w.pop_front();
          void'(tok_due.pop_front());
        end
        if (rd_m) void'(exp_q.pop_front());
        if (arr) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(aw);
          else begin
            drop_raw++;
            ovf_m = 1'b1;
          end
        end
        if (in_valid) begin
          tok_w.push_back(exp_word(x, y));
          tok_due.push_back(cyc + LAT);
        end
      end
    end
  end

  function automatic logic [CW-1:0] exp_dc();
    return (drop_raw > 255) ? {CW{1'b1}} : CW'(drop_raw);
  endfunction

  function automatic logic [W-1:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = v;
    x = a;
    y = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic rand_operands();
    x = WIDTH'($urandom());
    y = WIDTH'($urandom());
    if ($urandom_range(0, 3) == 0) x[17:0] = '1;
    if ($urandom_range(0, 3) == 0) y = WIDTH'($urandom_range(0, 3));
  endtask

  // tests
  task automatic test_reset();
    #2;
    n_tests++;
    if (out_valid !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: out_valid=%b full=%b, required 0 0", out_valid, full);
    end
    n_tests++;
    if (out_data !== '0 || out_lcy !== 1'b0 || out_mcy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: data=%h lcy=%b mcy=%b, required 0", out_data, out_lcy, out_mcy);
    end
    n_tests++;
    if (overflow !== 1'b0 || drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_drop: overflow=%b drop_cnt=%0d, required 0 0", overflow, drop_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] ed, input logic el, input logic em);
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, a, b);
    @(negedge clk);
    drive(1'b0, '0, '0);
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_early: out_valid=%b, required 0", nm, out_valid);
      end
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== ed || out_lcy !== el || out_mcy !== em) begin
      n_fail++;
      $display("FAIL %s_result: valid=%b data=%h lcy=%b mcy=%b, required 1 %h %b %b",
               nm, out_valid, out_data, out_lcy, out_mcy, ed, el, em);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after: out_valid=%b, required 0", nm, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[4];
    logic [W-1:0] prev;
    logic         prev_v;
    out_ready = 1'b0;
    prev_v = 1'b0;
    prev = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_tests++;
        if (out_valid !== (exp_q.size() != 0) || {out_data, out_lcy, out_mcy} !== exp_head()) begin
          n_fail++;
          $display("FAIL b2b_model: valid=%b word=%h, required %b %h", out_valid,
                   {out_data, out_lcy, out_mcy}, exp_q.size() != 0, exp_head());
        end
        if (prev_v) begin
          n_tests++;
          if ({out_data, out_lcy, out_mcy} !== prev) begin
            n_fail++;
            $display("FAIL b2b_stall_stable: word=%h, required %h", {out_data, out_lcy, out_mcy}, prev);
          end
        end
      end
      if (i == 8) begin
        n_tests++;
        if (full !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_full: full=%b, required 1", full);
        end
      end
      prev_v = out_valid;
      prev = {out_data, out_lcy, out_mcy};
      if (i < 4) begin
        rand_operands();
        in_valid = 1'b1;
        words[i] = exp_word(x, y);
      end else begin
        in_valid = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || {out_data, out_lcy, out_mcy} !== words[i]) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: valid=%b word=%h, required 1 %h", i, out_valid,
                 {out_data, out_lcy, out_mcy}, words[i]);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (out_valid !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drained: valid=%b full=%b, required 0 0", out_valid, full);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] words[7];
    logic [W-1:0] tail[4];
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rand_operands();
      in_valid = 1'b1;
      words[i] = exp_word(x, y);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (drop_cnt !== 8'd3 || overflow !== 1'b1 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drops: drop_cnt=%0d overflow=%b full=%b, required 3 1 1",
               drop_cnt, overflow, full);
    end
    n_tests++;
    if ({out_data, out_lcy, out_mcy} !== words[0]) begin
      n_fail++;
      $display("FAIL ovf_head: word=%h, required %h", {out_data, out_lcy, out_mcy}, words[0]);
    end
    rand_operands();
    in_valid = 1'b1;
    tail[3] = exp_word(x, y);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (drop_cnt !== 8'd3 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_read_write: drop_cnt=%0d full=%b, required 3 1", drop_cnt, full);
    end
    tail[0] = words[1];
    tail[1] = words[2];
    tail[2] = words[3];
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || {out_data, out_lcy, out_mcy} !== tail[i]) begin
        n_fail++;
        $display("FAIL ovf_contents[%0d]: valid=%b word=%h, required 1 %h", i, out_valid,
                 {out_data, out_lcy, out_mcy}, tail[i]);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: valid=%b overflow=%b, required 0 1", out_valid, overflow);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rand_operands();
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (drop_cnt2 !== 2'd3 || overflow2 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_cw2: drop_cnt=%0d overflow=%b, required 3 1", drop_cnt2, overflow2);
    end
    n_tests++;
    if (drop_cnt !== 8'd5 || drop_cnt !== exp_dc()) begin
      n_fail++;
      $display("FAIL sat_cw8: drop_cnt=%0d, required 5 (model %0d)", drop_cnt, exp_dc());
    end
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_operands();
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: out_valid=%b, required 1", out_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || full !== 1'b0 || out_data !== '0 || out_lcy !== 1'b0 ||
        out_mcy !== 1'b0 || overflow !== 1'b0 || drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL arst_clear: valid=%b full=%b data=%h lcy=%b mcy=%b ovf=%b drops=%0d, required all 0",
               out_valid, full, out_data, out_lcy, out_mcy, overflow, drop_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_stale[%0d]: out_valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== (exp_q.size() != 0) || full !== (exp_q.size() == DEPTH) ||
          {out_data, out_lcy, out_mcy} !== exp_head()) begin
        n_fail++;
        $display("FAIL random_head @%0d: valid=%b full=%b word=%h, required %b %b %h", i,
                 out_valid, full, {out_data, out_lcy, out_mcy},
                 exp_q.size() != 0, exp_q.size() == DEPTH, exp_head());
      end
      n_tests++;
      if (drop_cnt !== exp_dc() || overflow !== ovf_m) begin
        n_fail++;
        $display("FAIL random_drops @%0d: drop_cnt=%0d overflow=%b, required %0d %b", i,
                 drop_cnt, overflow, exp_dc(), ovf_m);
      end
      rand_operands();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single("single", 28'h00001FF, 28'h0000001, 28'h0000200, CY, 1'b0);
    test_single("double", 28'h003FFFF, 28'h0000001, 28'h0040000, CY, CY);
    test_back_to_back();
    test_overflow();
    test_saturation();
    test_async_reset();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
